// File: rtl/tdes_round_sequencer_if.sv
// Control/strobe bundle between the Triple-DES round sequencer and its
// neighbours: start/mode/abort from the register side, strobes to the datapath.
interface tdes_round_sequencer_if;
    logic       start;
    logic       mode_decrypt;
    logic       abort;
    logic       busy;
    logic       load_data;
    logic       load_key;
    logic [1:0] key_sel;
    logic [1:0] pass_idx;
    logic       pass_decrypt;
    logic [3:0] round_idx;
    logic       round_en;
    logic [1:0] shift_amt;
    logic       shift_right;
    logic       pass_end;
    logic       out_valid;

    modport master (
        output start, mode_decrypt, abort,
        input  busy, load_data, load_key, key_sel, pass_idx, pass_decrypt,
               round_idx, round_en, shift_amt, shift_right, pass_end, out_valid
    );

    modport slave (
        input  start, mode_decrypt, abort,
        output busy, load_data, load_key, key_sel, pass_idx, pass_decrypt,
               round_idx, round_en, shift_amt, shift_right, pass_end, out_valid
    );
endinterface

// File: rtl/tdes_round_sequencer.sv
// Control FSM for the iterative Triple-DES core: sequences LOAD_KEY / ROUND /
// PASS_END over three DES passes (E-D-E or D-E-D) and drives datapath strobes.
module tdes_round_sequencer #(
    parameter int NUM_ROUNDS   = 16,
    parameter int NUM_PASSES   = 3,
    parameter int ROUND_CYCLES = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    tdes_round_sequencer_if.slave   seq_if
);

    localparam int SUB_W = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;
    localparam logic [SUB_W-1:0] SUB_ZERO   = SUB_W'(0);
    localparam logic [SUB_W-1:0] SUB_ONE    = SUB_W'(1);
    localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(ROUND_CYCLES - 1);
    localparam logic [3:0]       ROUND_LAST = 4'(NUM_ROUNDS - 1);
    localparam logic [1:0]       PASS_LAST  = 2'(NUM_PASSES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_KEY = 3'd1,
        S_ROUND    = 3'd2,
        S_PASS_END = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       pass_q, pass_d;
    logic [3:0]       round_q, round_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic             mode_q, mode_d;

    logic       busy_q, busy_d;
    logic       load_data_q, load_data_d;
    logic       load_key_q, load_key_d;
    logic [1:0] key_sel_q, key_sel_d;
    logic       pass_decrypt_q, pass_decrypt_d;
    logic       round_en_q, round_en_d;
    logic [1:0] shift_amt_q, shift_amt_d;
    logic       shift_right_q, shift_right_d;
    logic       pass_end_q, pass_end_d;
    logic       out_valid_q, out_valid_d;

    // Key-schedule rotation: encrypt rotates left by 1 on rounds 0,1,8,15;
    // decrypt undoes it rotating right, starting from an already-aligned key.
    function automatic logic [1:0] shift_of(input logic [3:0] rnd, input logic dec);
        logic [1:0] amt;
        if (rnd == 4'd1 || rnd == 4'd8 || rnd == 4'd15) begin
            amt = 2'd1;
        end else if (rnd == 4'd0) begin
            amt = dec ? 2'd0 : 2'd1;
        end else begin
            amt = 2'd2;
        end
        return amt;
    endfunction

    // Next-state and counter update; abort overrides every transition out of a busy state.
    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        round_d = round_q;
        sub_d   = sub_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (seq_if.start) begin
                    state_d = S_LOAD_KEY;
                    pass_d  = 2'd0;
                    round_d = 4'd0;
                    sub_d   = SUB_ZERO;
                    mode_d  = seq_if.mode_decrypt;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD_KEY: begin
                state_d = S_ROUND;
                round_d = 4'd0;
                sub_d   = SUB_ZERO;
            end
            S_ROUND: begin
                if (sub_q == SUB_LAST) begin
                    sub_d = SUB_ZERO;
                    if (round_q == ROUND_LAST) begin
                        state_d = S_PASS_END;
                        round_d = 4'd0;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end else begin
                    sub_d = sub_q + SUB_ONE;
                end
            end
            S_PASS_END: begin
                if (pass_q < PASS_LAST) begin
                    state_d = S_LOAD_KEY;
                    pass_d  = pass_q + 2'd1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                pass_d  = 2'd0;
                round_d = 4'd0;
                sub_d   = SUB_ZERO;
            end
            default: begin
                state_d = S_IDLE;
                pass_d  = 2'd0;
                round_d = 4'd0;
                sub_d   = SUB_ZERO;
            end
        endcase
        if (seq_if.abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            pass_d  = 2'd0;
            round_d = 4'd0;
            sub_d   = SUB_ZERO;
        end else begin
            state_d = state_d;
        end
    end

    // Output decode from the next state so every strobe leaves a flop.
    always_comb begin
        busy_d         = (state_d != S_IDLE);
        load_key_d     = (state_d == S_LOAD_KEY);
        load_data_d    = (state_d == S_LOAD_KEY) && (pass_d == 2'd0);
        round_en_d     = (state_d == S_ROUND) && (sub_d == SUB_LAST);
        pass_end_d     = (state_d == S_PASS_END);
        out_valid_d    = (state_d == S_DONE);
        pass_decrypt_d = 1'b0;
        key_sel_d      = 2'd0;
        shift_amt_d    = 2'd0;
        shift_right_d  = 1'b0;
        if (state_d != S_IDLE) begin
            pass_decrypt_d = mode_d ^ pass_d[0];
            key_sel_d      = mode_d ? (2'd2 - pass_d) : pass_d;
        end else begin
            pass_decrypt_d = 1'b0;
            key_sel_d      = 2'd0;
        end
        if (state_d == S_ROUND) begin
            shift_amt_d   = shift_of(round_d, pass_decrypt_d);
            shift_right_d = pass_decrypt_d;
        end else begin
            shift_amt_d   = 2'd0;
            shift_right_d = 1'b0;
        end
    end

    // State, counters and registered outputs; synchronous reset wins over abort.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= S_IDLE;
            pass_q         <= 2'd0;
            round_q        <= 4'd0;
            sub_q          <= SUB_ZERO;
            mode_q         <= 1'b0;
            busy_q         <= 1'b0;
            load_data_q    <= 1'b0;
            load_key_q     <= 1'b0;
            key_sel_q      <= 2'd0;
            pass_decrypt_q <= 1'b0;
            round_en_q     <= 1'b0;
            shift_amt_q    <= 2'd0;
            shift_right_q  <= 1'b0;
            pass_end_q     <= 1'b0;
            out_valid_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            pass_q         <= pass_d;
            round_q        <= round_d;
            sub_q          <= sub_d;
            mode_q         <= mode_d;
            busy_q         <= busy_d;
            load_data_q    <= load_data_d;
            load_key_q     <= load_key_d;
            key_sel_q      <= key_sel_d;
            pass_decrypt_q <= pass_decrypt_d;
            round_en_q     <= round_en_d;
            shift_amt_q    <= shift_amt_d;
            shift_right_q  <= shift_right_d;
            pass_end_q     <= pass_end_d;
            out_valid_q    <= out_valid_d;
        end
    end

    assign seq_if.busy         = busy_q;
    assign seq_if.load_data    = load_data_q;
    assign seq_if.load_key     = load_key_q;
    assign seq_if.key_sel      = key_sel_q;
    assign seq_if.pass_idx     = pass_q;
    assign seq_if.pass_decrypt = pass_decrypt_q;
    assign seq_if.round_idx    = round_q;
    assign seq_if.round_en     = round_en_q;
    assign seq_if.shift_amt    = shift_amt_q;
    assign seq_if.shift_right  = shift_right_q;
    assign seq_if.pass_end     = pass_end_q;
    assign seq_if.out_valid    = out_valid_q;

endmodule

// File: tb/tb_tdes_round_sequencer.sv
// Directed scoreboard bench for tdes_round_sequencer: full per-cycle expected
// traces are queued at start and compared cycle by cycle for two instances.
module tb_tdes_round_sequencer;

    logic clk;
    logic rst;

    tdes_round_sequencer_if b1 ();
    tdes_round_sequencer_if b2 ();

    tdes_round_sequencer #(.NUM_ROUNDS(16), .NUM_PASSES(3), .ROUND_CYCLES(1)) dut1 (
        .clk_i  (clk),
        .rst_i  (rst),
        .seq_if (b1)
    );

    tdes_round_sequencer #(.NUM_ROUNDS(16), .NUM_PASSES(3), .ROUND_CYCLES(2)) dut2 (
        .clk_i  (clk),
        .rst_i  (rst),
        .seq_if (b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {busy, load_data, load_key, key_sel, pass_idx, pass_decrypt, round_idx,
    //  round_en, shift_amt, shift_right, pass_end, out_valid}
    typedef logic [17:0] vec_t;

    logic [1:0] enc_tab [16] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    logic [1:0] dec_tab [16] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

    vec_t q1 [$];
    vec_t q2 [$];
    int   checks = 0;
    int   errors = 0;
    int   sum [4];
    int   ov_count;

    function automatic vec_t mk(input logic bsy, input logic ld, input logic lk,
                                input logic [1:0] ks, input logic [1:0] pi, input logic pd,
                                input logic [3:0] ri, input logic re, input logic [1:0] sa,
                                input logic sr, input logic pe, input logic ov);
        return {bsy, ld, lk, ks, pi, pd, ri, re, sa, sr, pe, ov};
    endfunction

    function automatic vec_t obs(input logic bsy, input logic ld, input logic lk,
                                 input logic [1:0] ks, input logic [1:0] pi, input logic pd,
                                 input logic [3:0] ri, input logic re, input logic [1:0] sa,
                                 input logic sr, input logic pe, input logic ov);
        return {bsy, ld, lk, ks, pi, pd, ri, re, sa, sr, pe, ov};
    endfunction

    task automatic push_vec(input int which, input vec_t v);
        if (which == 1) q1.push_back(v);
        else            q2.push_back(v);
    endtask

    // Expected trace from cycle 1 (LOAD_KEY of pass 0) through the DONE cycle.
    task automatic push_op(input int which, input logic dec_mode, input int rc);
        logic [1:0] ks;
        logic [1:0] pi;
        logic       pd;
        logic [1:0] sa;
        for (int p = 0; p < 3; p++) begin
            pi = 2'(p);
            pd = dec_mode ^ pi[0];
            ks = dec_mode ? 2'(2 - p) : pi;
            push_vec(which, mk(1'b1, (p == 0), 1'b1, ks, pi, pd, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
            for (int r = 0; r < 16; r++) begin
                sa = pd ? dec_tab[r] : enc_tab[r];
                for (int s = 0; s < rc; s++) begin
                    push_vec(which, mk(1'b1, 1'b0, 1'b0, ks, pi, pd, 4'(r), (s == rc - 1),
                                       sa, pd, 1'b0, 1'b0));
                end
            end
            push_vec(which, mk(1'b1, 1'b0, 1'b0, ks, pi, pd, 4'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0));
        end
        pd = dec_mode;
        ks = dec_mode ? 2'd0 : 2'd2;
        push_vec(which, mk(1'b1, 1'b0, 1'b0, ks, 2'd2, pd, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1));
    endtask

    task automatic check_vec(input string tag, input vec_t o, input vec_t e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%05h expected=%05h at t=%0t", tag, o, e, $time);
        end
    endtask

    task automatic check_int(input string tag, input int o, input int e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    // Advance one clock and compare both instances against their scoreboards.
    task automatic step();
        vec_t o1;
        vec_t o2;
        vec_t e1;
        vec_t e2;
        @(posedge clk);
        #1;
        o1 = obs(b1.busy, b1.load_data, b1.load_key, b1.key_sel, b1.pass_idx, b1.pass_decrypt,
                 b1.round_idx, b1.round_en, b1.shift_amt, b1.shift_right, b1.pass_end, b1.out_valid);
        o2 = obs(b2.busy, b2.load_data, b2.load_key, b2.key_sel, b2.pass_idx, b2.pass_decrypt,
                 b2.round_idx, b2.round_en, b2.shift_amt, b2.shift_right, b2.pass_end, b2.out_valid);
        e1 = (q1.size() > 0) ? q1.pop_front() : '0;
        e2 = (q2.size() > 0) ? q2.pop_front() : '0;
        check_vec("dut1_cycle", o1, e1);
        check_vec("dut2_cycle", o2, e2);
        if (b1.round_en === 1'b1) sum[b1.pass_idx] += int'(b1.shift_amt);
        if (b1.out_valid === 1'b1) ov_count++;
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 4; i++) sum[i] = 0;
        ov_count = 0;
    endtask

    initial begin
        rst = 1'b1;
        b1.start = 1'b0; b1.mode_decrypt = 1'b0; b1.abort = 1'b0;
        b2.start = 1'b0; b2.mode_decrypt = 1'b0; b2.abort = 1'b0;
        clear_stats();
        step(); step();
        rst = 1'b0;
        step(); step();

        // Encrypt-mode operation, default timing
        clear_stats();
        b1.mode_decrypt = 1'b0; b1.start = 1'b1;
        push_op(1, 1'b0, 1);
        step();
        b1.start = 1'b0;
        repeat (54) step();
        step();
        check_int("enc_sum_pass0", sum[0], 28);
        check_int("enc_sum_pass1", sum[1], 27);
        check_int("enc_sum_pass2", sum[2], 28);
        check_int("enc_out_valid_count", ov_count, 1);

        // Decrypt-mode operation
        clear_stats();
        b1.mode_decrypt = 1'b1; b1.start = 1'b1;
        push_op(1, 1'b1, 1);
        step();
        b1.start = 1'b0; b1.mode_decrypt = 1'b0;
        repeat (54) step();
        step();
        check_int("dec_sum_pass0", sum[0], 27);
        check_int("dec_sum_pass1", sum[1], 28);
        check_int("dec_sum_pass2", sum[2], 27);
        check_int("dec_out_valid_count", ov_count, 1);

        // Abort at c30, restart at c33, out_valid at c88
        clear_stats();
        b1.start = 1'b1;
        push_op(1, 1'b0, 1);
        step();
        b1.start = 1'b0;
        repeat (29) step();
        b1.abort = 1'b1;
        q1.delete();
        step();
        b1.abort = 1'b0;
        step(); step();
        b1.start = 1'b1;
        push_op(1, 1'b0, 1);
        step();
        b1.start = 1'b0;
        repeat (54) step();
        step();
        check_int("abort_out_valid_count", ov_count, 1);

        // Start pulses and mode flips while busy are ignored
        clear_stats();
        b1.start = 1'b1; b1.mode_decrypt = 1'b0;
        push_op(1, 1'b0, 1);
        step();
        b1.start = 1'b0;
        repeat (9) step();
        b1.start = 1'b1; b1.mode_decrypt = 1'b1;
        step();
        b1.start = 1'b0;
        repeat (43) step();
        b1.start = 1'b1;
        step();
        b1.start = 1'b0; b1.mode_decrypt = 1'b0;
        step(); step();
        check_int("busy_start_out_valid_count", ov_count, 1);

        // Start and abort together in IDLE: start wins
        b1.start = 1'b1; b1.abort = 1'b1; b1.mode_decrypt = 1'b1;
        push_op(1, 1'b1, 1);
        step();
        b1.start = 1'b0; b1.abort = 1'b0; b1.mode_decrypt = 1'b0;
        repeat (54) step();

        // Abort in IDLE has no effect
        b1.abort = 1'b1;
        step();
        b1.abort = 1'b0;
        step();

        // Reset mid-operation
        b1.start = 1'b1;
        push_op(1, 1'b0, 1);
        step();
        b1.start = 1'b0;
        repeat (19) step();
        rst = 1'b1;
        q1.delete();
        step();
        rst = 1'b0;
        step(); step();

        // Two cycles per round: out_valid at cycle 103
        b2.start = 1'b1; b2.mode_decrypt = 1'b1;
        push_op(2, 1'b1, 2);
        step();
        b2.start = 1'b0; b2.mode_decrypt = 1'b0;
        repeat (102) step();
        step(); step();

        check_int("q1_drained", q1.size(), 0);
        check_int("q2_drained", q2.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
